mod2011_chunk_reducer: RTL and testbench
========================================

# mod2011_chunk_reducer

Sequential reducer that computes a 500-bit operand modulo 2011 by walking it in 6-bit chunks. Each chunk goes, with its chunk index, to the shared 6-input residue LUT bank, which returns the 11-bit residue of that chunk at its weight. The block accumulates the residues modulo 2011 and returns the final residue over a valid/ready handshake. It sits between the operand producer and the downstream modular datapath, and it is the only master of the LUT bank.

## Interface
- W, 500: operand width in bits.
- CHUNK, 6: chunk width; matches the LUT input width.
- MOD, 2011: modulus.
- RW, 11: residue width, ceil(log2(MOD)).
- NCHUNK, 84: chunk count, ceil(W/CHUNK).
- IW, 7: chunk index width, ceil(log2(NCHUNK)).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  block accepts operand (IDLE only).
- in_op  in  W  operand, little-endian chunks.
- lut_idx  out  IW  chunk index presented to the LUT bank.
- lut_x  out  CHUNK  chunk value presented to the LUT bank.
- lut_z  in  RW  residue of lut_x·2^(CHUNK·lut_idx) mod MOD; combinational from the bank.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_res  out  RW  operand mod MOD.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load in_op into the operand shift register (zero-padded to NCHUNK·CHUNK = 504 bits), clear acc and idx, go to RUN.
- RUN:
  - lut_idx=idx; lut_x=opreg[CHUNK-1:0].
  - Each cycle: acc ← addmod(acc, lut_z); opreg ← opreg >> CHUNK; idx ← idx+1.
  - After the accumulate with idx==NCHUNK-1, go to DONE.
  - The last chunk carries 2 valid bits (in_op[499:498]) over 4 zero pad bits.
- addmod: s = acc + lut_z, 12 bits; result is s−MOD if s ≥ MOD, else s. acc is always < MOD.
- lut_z ≥ MOD is outside contract; out_res is then unspecified. No error flag.
- DONE:
  - out_valid=1; out_res=acc, held stable.
  - On out_ready: go to IDLE.
- lut_idx and lut_x are 0 outside RUN.
- in_ready is 0 in DONE. A new operand is accepted no earlier than the cycle after the result handshake; the block never overlaps operations.

## Timing
- Reset (async assert, synchronous-release safe): state=IDLE, acc=0, idx=0, opreg=0.
- Output values during reset: in_ready=1 once released, out_valid=0, out_res=0, busy=0, lut_idx=0, lut_x=0.
- Accept at edge T → RUN in cycles T+1..T+NCHUNK (84 LUT lookups) → out_valid high from cycle T+85.
- Throughput: one operand per NCHUNK+2 cycles with out_ready held high.
- out_ready low: out_valid and out_res are held indefinitely.
- out_ready high without out_valid is ignored.
- in_valid outside IDLE is ignored; in_op is sampled only on the accept edge.
- rst asserted mid-RUN or in DONE: the operation is dropped, no result is produced, and all outputs take their reset values immediately.

## Configuration
- MOD2011_LUT_REG_EN:
  - Defined: lut_z is registered inside the block before addmod, to close timing on the LUT bank path. RUN lasts NCHUNK+1 cycles: the first cycle only fills the register, and accumulation lags lut_idx by one. out_valid rises at T+86. lut_idx/lut_x still advance once per cycle and hold 0 in the final drain cycle.
  - Undefined: combinational lut_z; latency as given under Timing.

## Test plan
- Bench LUT model: lut_z = (lut_x·2^(6·lut_idx)) mod 2011.
- in_op=0 → out_res=0, out_valid at T+85 (T+86 with MOD2011_LUT_REG_EN); busy high across T+1..T+85.
- in_op=4021 → out_res=2010; in_op=2011 → out_res=0; in_op=2010 → out_res=2010. Checks the conditional subtract at the boundary.
- in_op=2^499 (only the top bit set) → out_res = model value. With random 500-bit operands (≥1000), out_res matches a bignum mod 2011.
- out_ready held low 10 cycles after out_valid → out_res stable and in_ready=0 throughout; one cycle after out_ready=1, in_ready=1.
- rst pulsed at RUN cycle 40 → out_valid=0, out_res=0, busy=0 immediately. A following operand 4021 gives out_res=2010 with normal latency.
- in_valid held high continuously with back-to-back operands → exactly one accept per NCHUNK+2 cycles, and no operand is sampled outside IDLE.

Source files
------------

// File: rtl/mod2011_chunk_reducer.sv
// mod2011_chunk_reducer: reduces a 500-bit operand modulo 2011, one 6-bit chunk per cycle, via an external residue LUT bank.
// Define MOD2011_LUT_REG_EN to register lut_z ahead of the modular add (one extra cycle of latency).
module mod2011_chunk_reducer #(
   parameter int W      = 500,
   parameter int CHUNK  = 6,
   parameter int MOD    = 2011,
   parameter int RW     = 11,
   parameter int NCHUNK = 84,
   parameter int IW     = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_op,
   output logic [IW-1:0]     lut_idx,
   output logic [CHUNK-1:0]  lut_x,
   input  logic [RW-1:0]     lut_z,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RW-1:0]     out_res,
   output logic              busy
);

   localparam int OPW = NCHUNK * CHUNK;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [RW-1:0]    r_acc;
   logic [IW-1:0]    r_idx;
   logic [OPW-1:0]   r_op;

   logic             w_lookup;
   logic             w_last;
   logic [RW-1:0]    w_addend;
   logic [RW:0]      w_sum;
   logic [RW-1:0]    w_acc_next;

`ifdef MOD2011_LUT_REG_EN
   logic [RW-1:0]    r_lut_z;

   // Lookups run for idx 0..NCHUNK-1; the extra cycle at idx==NCHUNK only drains r_lut_z.
   assign w_lookup = (r_state == S_RUN) && (r_idx < IW'(NCHUNK));
   assign w_last   = (r_idx == IW'(NCHUNK));
   assign w_addend = r_lut_z;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_lut_z <= '0;
      else if (w_lookup)
         r_lut_z <= lut_z;
      else
         r_lut_z <= '0;
   end
`else
   assign w_lookup = (r_state == S_RUN);
   assign w_last   = (r_idx == IW'(NCHUNK - 1));
   assign w_addend = lut_z;
`endif

   // Both inputs are below MOD, so one conditional subtract keeps the sum reduced.
   assign w_sum      = {1'b0, r_acc} + {1'b0, w_addend};
   assign w_acc_next = (w_sum >= (RW+1)'(MOD)) ? RW'(w_sum - (RW+1)'(MOD)) : w_sum[RW-1:0];

   assign lut_idx   = w_lookup ? r_idx : '0;
   assign lut_x     = w_lookup ? r_op[CHUNK-1:0] : '0;
   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign out_res   = out_valid ? r_acc : '0;
   assign busy      = (r_state != S_IDLE);

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   // NOTE: the operand register is plain flops (not a RAM), so resetting it is cheap and keeps lut_x clean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_idx   <= '0;
         r_op    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op    <= OPW'(in_op);
                  r_acc   <= '0;
                  r_idx   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= w_acc_next;
               r_idx <= r_idx + 1'b1;
               r_op  <= r_op >> CHUNK;
               if (w_last)
                  r_state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod2011_chunk_reducer.sv
// Self-checking bench for mod2011_chunk_reducer: directed vector table, reset/stall sequences, and
// randomized back-to-back operands checked against a bit-serial bignum mod-2011 reference.
module tb_mod2011_chunk_reducer;

   localparam int W      = 500;
   localparam int CHUNK  = 6;
   localparam int MOD    = 2011;
   localparam int RW     = 11;
   localparam int NCHUNK = 84;
   localparam int IW     = 7;
`ifdef MOD2011_LUT_REG_EN
   localparam int LAT    = NCHUNK + 1;
`else
   localparam int LAT    = NCHUNK;
`endif
   localparam int PERIOD = LAT + 2;
   localparam int NRAND  = 1000;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_op;
   logic [IW-1:0]     lut_idx;
   logic [CHUNK-1:0]  lut_x;
   logic [RW-1:0]     lut_z;
   logic              out_valid;
   logic              out_ready;
   logic [RW-1:0]     out_res;
   logic              busy;

   int n_checks = 0;
   int n_errors = 0;

   mod2011_chunk_reducer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .lut_idx   (lut_idx),
      .lut_x     (lut_x),
      .lut_z     (lut_z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // LUT bank model: residue of x * 2^(6*idx) mod 2011.
   function automatic logic [RW-1:0] lut_fn(input logic [CHUNK-1:0] x, input logic [IW-1:0] idx);
      int p;
      p = 1;
      for (int j = 0; j < CHUNK * int'(idx); j++) p = (p * 2) % MOD;
      return RW'((int'(x) * p) % MOD);
   endfunction

   assign lut_z = lut_fn(lut_x, lut_idx);

   // Reference: bit-serial Horner evaluation of the whole operand mod 2011.
   function automatic int ref_mod(input logic [W-1:0] x);
      int r;
      r = 0;
      for (int i = W - 1; i >= 0; i--) r = (r * 2 + int'(x[i])) % MOD;
      return r;
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic [511:0] t;
      for (int k = 0; k < 16; k++) t[k*32 +: 32] = $urandom;
      return t[W-1:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One full operation starting just after a negedge with the block idle.
   task automatic run_op(input logic [W-1:0] op, input int exp, input string name, input int stall);
      int k;
      int bad;
      k = 0;
      while (!in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check({name, "_ready"}, 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      in_op    = op;
      @(negedge clk);
      in_valid = 1'b0;
      in_op    = rand_op();
      k   = 0;
      bad = 0;
      while (!out_valid && k < 300) begin
         if (!busy || in_ready) bad++;
         @(negedge clk);
         k++;
      end
      check({name, "_latency"}, 64'(k), 64'(LAT));
      check({name, "_busy_run"}, 64'(bad), 64'(0));
      check({name, "_res"}, 64'(out_res), 64'(exp));
      bad = 0;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         if (out_res !== RW'(exp) || in_ready || !out_valid || !busy || lut_idx != 0 || lut_x != 0) bad++;
      end
      if (stall > 0) check({name, "_stall_hold"}, 64'(bad), 64'(0));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_idle_ready"}, 64'(in_ready), 64'(1));
      check({name, "_idle_valid"}, 64'(out_valid), 64'(0));
   endtask

   typedef struct {
      logic [W-1:0] op;
      int           exp;
      int           stall;
      string        name;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int k;
      int cyc;
      int last_acc;
      int n_res;
      int q[$];
      logic [W-1:0] op;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op     = '0;
      out_ready = 1'b0;

      vecs[0].op = '0;          vecs[0].exp = 0;    vecs[0].stall = 0;  vecs[0].name = "zero";
      vecs[1].op = W'(4021);    vecs[1].exp = 2010; vecs[1].stall = 10; vecs[1].name = "op4021";
      vecs[2].op = W'(2011);    vecs[2].exp = 0;    vecs[2].stall = 0;  vecs[2].name = "op2011";
      vecs[3].op = W'(2010);    vecs[3].exp = 2010; vecs[3].stall = 0;  vecs[3].name = "op2010";
      op = '0;
      op[W-1] = 1'b1;
      vecs[4].op = op;          vecs[4].exp = ref_mod(op); vecs[4].stall = 0; vecs[4].name = "top_bit";

      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_res", 64'(out_res), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_lut_idx", 64'(lut_idx), 64'(0));
      check("rst_lut_x", 64'(lut_x), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("rel_in_ready", 64'(in_ready), 64'(1));

      for (int v = 0; v < 5; v++) run_op(vecs[v].op, vecs[v].exp, vecs[v].name, vecs[v].stall);

      // Reset during RUN cycle 40.
      op = rand_op();
      in_valid = 1'b1;
      in_op    = op;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (39) @(negedge clk);
      check("mid_run_busy", 64'(busy), 64'(1));
      check("mid_run_lut_idx", 64'(lut_idx), 64'(39));
      check("mid_run_lut_x", 64'(lut_x), 64'(op[39*CHUNK +: CHUNK]));
      #1 rst = 1'b1;
      #1;
      check("run_rst_out_valid", 64'(out_valid), 64'(0));
      check("run_rst_out_res", 64'(out_res), 64'(0));
      check("run_rst_busy", 64'(busy), 64'(0));
      check("run_rst_lut_idx", 64'(lut_idx), 64'(0));
      check("run_rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(W'(4021), 2010, "after_rst", 0);

      // Reset while a result is waiting in DONE.
      in_valid = 1'b1;
      in_op    = W'(4021);
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("done_before_rst", 64'(out_valid), 64'(1));
      #1 rst = 1'b1;
      #1;
      check("done_rst_out_valid", 64'(out_valid), 64'(0));
      check("done_rst_out_res", 64'(out_res), 64'(0));
      check("done_rst_busy", 64'(busy), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back random operands, in_valid and out_ready held high, in_op changing every cycle.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      cyc       = 0;
      last_acc  = -1;
      n_res     = 0;
      while (n_res < NRAND && cyc < NRAND * PERIOD + 500) begin
         if (out_valid) begin
            if (q.size() == 0) check("rand_spurious", 64'(1), 64'(0));
            else check("rand_res", 64'(out_res), 64'(q.pop_front()));
            n_res++;
         end
         in_op = rand_op();
         if (in_ready) begin
            q.push_back(ref_mod(in_op));
            if (last_acc >= 0) check("accept_spacing", 64'(cyc - last_acc), 64'(PERIOD));
            last_acc = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      check("rand_count", 64'(n_res), 64'(NRAND));
      in_valid = 1'b0;
      k = 0;
      while (busy && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("final_idle", 64'(busy), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
